// File: rtl/mio_pkg.sv
// Shared types and address map for the memory/IO bus controller.
// Holds the FSM states, target selects and the address decode helper.
package mio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RAM_ACC  = 2'd1,
        ST_RAM_WAIT = 2'd2,
        ST_RESP     = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        TGT_RAM     = 3'd0,
        TGT_GPIO    = 3'd1,
        TGT_SW      = 3'd2,
        TGT_TMR_CNT = 3'd3,
        TGT_TMR_CMP = 3'd4,
        TGT_NONE    = 3'd5
    } target_e;

    localparam logic [3:0]  RAM_REGION   = 4'h0;
    localparam logic [31:0] GPIO_BASE    = 32'hE000_0000;
    localparam logic [31:0] SW_BASE      = 32'hF000_0000;
    localparam logic [31:0] TMR_CNT_ADDR = 32'hF000_0004;
    localparam logic [31:0] TMR_CMP_ADDR = 32'hF000_0008;
    localparam logic [31:0] WORD_MASK    = 32'hFFFF_FFFC;

    // Byte-lane bits are dropped so every register answers on its whole word.
    function automatic target_e decode_target(input logic [31:0] addr);
        target_e tgt;
        logic [31:0] word_addr;
        word_addr = addr & WORD_MASK;
        if (addr[31:28] == RAM_REGION) begin
            tgt = TGT_RAM;
        end else if (word_addr == GPIO_BASE) begin
            tgt = TGT_GPIO;
        end else if (word_addr == SW_BASE) begin
            tgt = TGT_SW;
        end else if (word_addr == TMR_CNT_ADDR) begin
            tgt = TGT_TMR_CNT;
        end else if (word_addr == TMR_CMP_ADDR) begin
            tgt = TGT_TMR_CMP;
        end else begin
            tgt = TGT_NONE;
        end
        return tgt;
    endfunction

endpackage

// File: rtl/mio_timer.sv
// Free-running 32-bit timer with a compare register and a sticky match flag.
// Register writes take priority over the increment and over a same-cycle match.
module mio_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic        cnt_we,
    input  logic        cmp_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        irq
);

    logic [31:0] count_r;
    logic [31:0] compare_r;
    logic        irq_r;
    logic        match_s;

    assign match_s = (count_r == compare_r);

    // Count, compare and sticky irq state.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r   <= 32'd0;
            compare_r <= 32'hFFFF_FFFF;
            irq_r     <= 1'b0;
        end else begin
            if (cnt_we) begin
                count_r <= wdata;
            end else begin
                count_r <= count_r + 32'd1;
            end

            if (cmp_we) begin
                compare_r <= wdata;
            end

            // Writing compare acknowledges the interrupt, even on a match.
            if (cmp_we) begin
                irq_r <= 1'b0;
            end else if (match_s) begin
                irq_r <= 1'b1;
            end
        end
    end

    assign count   = count_r;
    assign compare = compare_r;
    assign irq     = irq_r;

endmodule

// File: rtl/mio_bus_ctrl.sv
// Memory/IO bus controller between the CPU and RAM, GPIO, switches and timer.
// Every target completes through the same one-cycle mio_ready handshake.
module mio_bus_ctrl
    import mio_pkg::*;
#(
    parameter int          RAM_AW      = 10,
    parameter int          RAM_WAIT    = 2,
    parameter logic [31:0] UNMAPPED_RD = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              mio_ready,
    output logic              bus_err,
    output logic              ram_en,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    input  logic [15:0]       sw_in,
    output logic [15:0]       gpio_out,
    output logic              timer_irq
);

    localparam logic [3:0] WAIT_LOAD = (RAM_WAIT > 0) ? 4'(RAM_WAIT - 1) : 4'd0;

    state_e      state_r;
    logic [3:0]  wait_cnt_r;
    logic        we_r;
    logic [31:0] cap_r;
    logic [31:0] cpu_rdata_r;
    logic        ready_r;
    logic        bus_err_r;
    logic [15:0] gpio_r;

    target_e     tgt_s;
    logic        accept_s;
    logic        ram_sel_s;
    logic        cnt_we_s;
    logic        cmp_we_s;
    logic [31:0] periph_rdata_s;
    logic [31:0] tmr_count_s;
    logic [31:0] tmr_compare_s;
    logic        tmr_irq_s;

    assign tgt_s    = decode_target(cpu_addr);
    assign accept_s = (state_r == ST_IDLE) && cpu_req;

    // The RAM is synchronous, so its strobe must be live in the accept cycle
    // for read data to be ready when RAM_ACC captures it.
    assign ram_sel_s = accept_s && (tgt_s == TGT_RAM) && !reset;
    assign cnt_we_s  = accept_s && cpu_we && (tgt_s == TGT_TMR_CNT);
    assign cmp_we_s  = accept_s && cpu_we && (tgt_s == TGT_TMR_CMP);

    mio_timer u_timer (
        .clk     (clk),
        .reset   (reset),
        .cnt_we  (cnt_we_s),
        .cmp_we  (cmp_we_s),
        .wdata   (cpu_wdata),
        .count   (tmr_count_s),
        .compare (tmr_compare_s),
        .irq     (tmr_irq_s)
    );

    // Peripheral read-data selection for the current request.
    always_comb begin
        periph_rdata_s = 32'd0;
        case (tgt_s)
            TGT_GPIO:    periph_rdata_s = {16'h0000, gpio_r};
            TGT_SW:      periph_rdata_s = {16'h0000, sw_in};
            TGT_TMR_CNT: periph_rdata_s = tmr_count_s;
            TGT_TMR_CMP: periph_rdata_s = tmr_compare_s;
            TGT_NONE:    periph_rdata_s = UNMAPPED_RD;
            default:     periph_rdata_s = 32'd0;
        endcase
    end

    // Access FSM, GPIO register and registered CPU-side outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            wait_cnt_r  <= 4'd0;
            we_r        <= 1'b0;
            cap_r       <= 32'd0;
            cpu_rdata_r <= 32'd0;
            ready_r     <= 1'b0;
            bus_err_r   <= 1'b0;
            gpio_r      <= 16'h0000;
        end else begin
            ready_r   <= 1'b0;
            bus_err_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (cpu_req) begin
                        we_r <= cpu_we;
                        if (tgt_s == TGT_RAM) begin
                            state_r <= ST_RAM_ACC;
                        end else begin
                            if (cpu_we && (tgt_s == TGT_GPIO)) begin
                                gpio_r <= cpu_wdata[15:0];
                            end
                            cpu_rdata_r <= cpu_we ? 32'd0 : periph_rdata_s;
                            ready_r     <= 1'b1;
                            bus_err_r   <= (tgt_s == TGT_NONE);
                            state_r     <= ST_RESP;
                        end
                    end
                end
                ST_RAM_ACC: begin
                    if (RAM_WAIT > 0) begin
                        cap_r      <= we_r ? 32'd0 : ram_rdata;
                        wait_cnt_r <= WAIT_LOAD;
                        state_r    <= ST_RAM_WAIT;
                    end else begin
                        cpu_rdata_r <= we_r ? 32'd0 : ram_rdata;
                        ready_r     <= 1'b1;
                        state_r     <= ST_RESP;
                    end
                end
                ST_RAM_WAIT: begin
                    if (wait_cnt_r == 4'd0) begin
                        cpu_rdata_r <= cap_r;
                        ready_r     <= 1'b1;
                        state_r     <= ST_RESP;
                    end else begin
                        wait_cnt_r <= wait_cnt_r - 4'd1;
                    end
                end
                ST_RESP: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign ram_en    = ram_sel_s;
    assign ram_we    = ram_sel_s && cpu_we;
    assign ram_addr  = cpu_addr[RAM_AW+1:2];
    assign ram_wdata = cpu_wdata;

    assign cpu_rdata = cpu_rdata_r;
    assign mio_ready = ready_r;
    assign bus_err   = bus_err_r;
    assign gpio_out  = gpio_r;
    assign timer_irq = tmr_irq_s;

endmodule

// File: tb/tb_mio_bus_ctrl.sv
// Self-checking bench for mio_bus_ctrl: synchronous RAM model plus a
// scoreboard of expected (rdata, bus_err, latency) per CPU access.
module tb_mio_bus_ctrl;
    import mio_pkg::*;

    localparam int          RAM_AW      = 10;
    localparam int          RAM_WAIT    = 2;
    localparam logic [31:0] UNMAPPED_RD = 32'h0000_0000;
    localparam int          RAM_LAT     = 2 + RAM_WAIT;

    logic              clk;
    logic              reset;
    logic              cpu_req;
    logic              cpu_we;
    logic [31:0]       cpu_addr;
    logic [31:0]       cpu_wdata;
    logic [31:0]       cpu_rdata;
    logic              mio_ready;
    logic              bus_err;
    logic              ram_en;
    logic              ram_we;
    logic [RAM_AW-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;
    logic [15:0]       sw_in;
    logic [15:0]       gpio_out;
    logic              timer_irq;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    int   nchecks = 0;
    int   nfail   = 0;

    int                ram_we_cycles = 0;
    int                ram_en_cycles = 0;
    logic [RAM_AW-1:0] last_ram_addr = '0;
    logic [31:0]       mem [0:(1<<RAM_AW)-1];

    mio_bus_ctrl #(
        .RAM_AW      (RAM_AW),
        .RAM_WAIT    (RAM_WAIT),
        .UNMAPPED_RD (UNMAPPED_RD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .mio_ready (mio_ready),
        .bus_err   (bus_err),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .sw_in     (sw_in),
        .gpio_out  (gpio_out),
        .timer_irq (timer_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < (1<<RAM_AW); i++) mem[i] = 32'd0;
        ram_rdata = 32'd0;
    end

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            ram_rdata <= mem[ram_addr];
        end
    end

    always @(negedge clk) begin
        if (ram_en) begin
            ram_en_cycles = ram_en_cycles + 1;
            last_ram_addr = ram_addr;
        end
        if (ram_we) ram_we_cycles = ram_we_cycles + 1;
    end

    // Drives one access, scrambles the inputs after acceptance, waits for mio_ready.
    task automatic cpu_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              output logic [31:0] rdata, output logic err, output int lat);
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        lat = 0; rdata = 32'd0; err = 1'b0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                cpu_addr = ~addr; cpu_wdata = ~wdata; cpu_we = ~we;
            end
        end while (!mio_ready && lat < 40);
        if (mio_ready) begin
            rdata = cpu_rdata; err = bus_err;
        end else begin
            lat = -1;
        end
        cpu_req = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0000_0040; cpu_wdata = 32'h1;
        repeat (3) @(negedge clk);
        nchecks++; if (ram_en !== 1'b0) begin nfail++; $display("FAIL rst_ram_en: got %b expected 0", ram_en); end
        nchecks++; if (ram_we !== 1'b0) begin nfail++; $display("FAIL rst_ram_we: got %b expected 0", ram_we); end
        nchecks++; if (mio_ready !== 1'b0 || bus_err !== 1'b0) begin nfail++; $display("FAIL rst_ready_err: got %b%b expected 00", mio_ready, bus_err); end
        nchecks++; if (cpu_rdata !== 32'd0) begin nfail++; $display("FAIL rst_rdata: got %h expected 0", cpu_rdata); end
        nchecks++; if (gpio_out !== 16'd0 || timer_irq !== 1'b0) begin nfail++; $display("FAIL rst_gpio_irq: got %h/%b expected 0/0", gpio_out, timer_irq); end
        cpu_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_ram();
        logic [31:0] rd; logic er; int lat; exp_t e; int we0; int en0;
        we0 = ram_we_cycles; en0 = ram_en_cycles;
        sb_q.push_back('{32'd0, 1'b0, RAM_LAT});
        cpu_access(1'b1, 32'h0000_0040, 32'h1234_5678, rd, er, lat);
        e = sb_q.pop_front();
        nchecks++; if (lat !== e.lat) begin nfail++; $display("FAIL ram_wr_lat: got %0d expected %0d", lat, e.lat); end
        nchecks++; if (rd !== e.rdata || er !== e.err) begin nfail++; $display("FAIL ram_wr_rdata: got %h/%b expected %h/%b", rd, er, e.rdata, e.err); end
        nchecks++; if (ram_we_cycles - we0 !== 1 || ram_en_cycles - en0 !== 1) begin nfail++; $display("FAIL ram_we_pulse: got we=%0d en=%0d expected 1/1", ram_we_cycles - we0, ram_en_cycles - en0); end
        nchecks++; if (last_ram_addr !== 10'h010) begin nfail++; $display("FAIL ram_addr: got %h expected 010", last_ram_addr); end

        sb_q.push_back('{32'h1234_5678, 1'b0, RAM_LAT});
        cpu_access(1'b0, 32'h0000_0040, 32'h0, rd, er, lat);
        e = sb_q.pop_front();
        nchecks++; if (lat !== e.lat) begin nfail++; $display("FAIL ram_rd_lat: got %0d expected %0d", lat, e.lat); end
        nchecks++; if (rd !== e.rdata || er !== e.err) begin nfail++; $display("FAIL ram_rd_data: got %h/%b expected %h/%b", rd, er, e.rdata, e.err); end

        sb_q.push_back('{32'd0, 1'b0, RAM_LAT});
        cpu_access(1'b1, 32'h0000_0044, 32'h0BAD_CAFE, rd, er, lat);
        e = sb_q.pop_front();
        nchecks++; if (lat !== e.lat || rd !== e.rdata) begin nfail++; $display("FAIL ram_wr2: got %0d/%h expected %0d/%h", lat, rd, e.lat, e.rdata); end
    endtask

    task automatic test_gpio();
        logic [31:0] rd; logic er; int lat; exp_t e;
        sb_q.push_back('{32'd0, 1'b0, 1});
        cpu_access(1'b1, 32'hE000_0000, 32'hFFFF_A5A5, rd, er, lat);
        e = sb_q.pop_front();
        nchecks++; if (gpio_out !== 16'hA5A5) begin nfail++; $display("FAIL gpio_out: got %h expected a5a5", gpio_out); end
        nchecks++; if (lat !== e.lat || rd !== e.rdata || er !== e.err) begin nfail++; $display("FAIL gpio_wr: got %0d/%h/%b expected %0d/%h/%b", lat, rd, er, e.lat, e.rdata, e.err); end
        sb_q.push_back('{32'h0000_A5A5, 1'b0, 1});
        cpu_access(1'b0, 32'hE000_0000, 32'h0, rd, er, lat);
        e = sb_q.pop_front();
        nchecks++; if (lat !== e.lat || rd !== e.rdata || er !== e.err) begin nfail++; $display("FAIL gpio_rd: got %0d/%h/%b expected %0d/%h/%b", lat, rd, er, e.lat, e.rdata, e.err); end
    endtask

    task automatic test_sw_unmapped();
        logic [31:0] rd; logic er; int lat; exp_t e;
        sw_in = 16'h00F0;
        sb_q.push_back('{32'h0000_00F0, 1'b0, 1});
        sb_q.push_back('{32'd0, 1'b0, 1});
        sb_q.push_back('{UNMAPPED_RD, 1'b1, 1});
        sb_q.push_back('{32'd0, 1'b1, 1});
        cpu_access(1'b0, 32'hF000_0000, 32'h0, rd, er, lat);
        e = sb_q.pop_front();
        nchecks++; if (lat !== e.lat || rd !== e.rdata || er !== e.err) begin nfail++; $display("FAIL sw_rd: got %0d/%h/%b expected %0d/%h/%b", lat, rd, er, e.lat, e.rdata, e.err); end
        cpu_access(1'b1, 32'hF000_0000, 32'h1234_0000, rd, er, lat);
        e = sb_q.pop_front();
        nchecks++; if (lat !== e.lat || rd !== e.rdata || er !== e.err) begin nfail++; $display("FAIL sw_wr: got %0d/%h/%b expected %0d/%h/%b", lat, rd, er, e.lat, e.rdata, e.err); end
        cpu_access(1'b0, 32'h7000_0000, 32'h0, rd, er, lat);
        e = sb_q.pop_front();
        nchecks++; if (lat !== e.lat || rd !== e.rdata || er !== e.err) begin nfail++; $display("FAIL unmapped_rd: got %0d/%h/%b expected %0d/%h/%b", lat, rd, er, e.lat, e.rdata, e.err); end
        cpu_access(1'b1, 32'h7000_0000, 32'h5555_5555, rd, er, lat);
        e = sb_q.pop_front();
        nchecks++; if (lat !== e.lat || rd !== e.rdata || er !== e.err) begin nfail++; $display("FAIL unmapped_wr: got %0d/%h/%b expected %0d/%h/%b", lat, rd, er, e.lat, e.rdata, e.err); end
        nchecks++; if (gpio_out !== 16'hA5A5) begin nfail++; $display("FAIL unmapped_side_effect: got %h expected a5a5", gpio_out); end
    endtask

    task automatic test_timer();
        logic [31:0] rd; logic er; int lat; int n; logic seen;
        cpu_access(1'b1, 32'hF000_0004, 32'd1000, rd, er, lat);
        cpu_access(1'b1, 32'hF000_0008, 32'd20, rd, er, lat);
        cpu_access(1'b1, 32'hF000_0004, 32'd10, rd, er, lat);
        nchecks++; if (timer_irq !== 1'b0) begin nfail++; $display("FAIL tmr_irq_early: got %b expected 0", timer_irq); end
        n = 0;
        do begin @(negedge clk); n++; end while (!timer_irq && n < 40);
        nchecks++; if (n !== 11) begin nfail++; $display("FAIL tmr_irq_rise: got %0d cycles expected 11", n); end
        seen = 1'b1;
        repeat (5) begin @(negedge clk); seen &= timer_irq; end
        nchecks++; if (seen !== 1'b1) begin nfail++; $display("FAIL tmr_irq_sticky: got %b expected 1", seen); end
        cpu_access(1'b1, 32'hF000_0004, 32'd19, rd, er, lat);
        nchecks++; if (timer_irq !== 1'b1) begin nfail++; $display("FAIL tmr_irq_cnt_wr: got %b expected 1", timer_irq); end
        cpu_access(1'b1, 32'hF000_0008, 32'd100, rd, er, lat);
        nchecks++; if (timer_irq !== 1'b0) begin nfail++; $display("FAIL tmr_irq_clear: got %b expected 0", timer_irq); end
        seen = 1'b0;
        repeat (10) begin @(negedge clk); seen |= timer_irq; end
        nchecks++; if (seen !== 1'b0) begin nfail++; $display("FAIL tmr_irq_stay_clr: got %b expected 0", seen); end
        sb_q.push_back('{32'd100, 1'b0, 1});
        cpu_access(1'b0, 32'hF000_0008, 32'h0, rd, er, lat);
        begin
            exp_t e;
            e = sb_q.pop_front();
            nchecks++; if (lat !== e.lat || rd !== e.rdata) begin nfail++; $display("FAIL tmr_cmp_rd: got %0d/%h expected %0d/%h", lat, rd, e.lat, e.rdata); end
        end
    endtask

    task automatic test_back_to_back();
        int n; exp_t e; logic [31:0] r; logic idle_rdy; logic idle_en; logic [RAM_AW-1:0] idle_addr; state_e idle_st;
        sb_q.push_back('{32'h1234_5678, 1'b0, RAM_LAT});
        sb_q.push_back('{32'h0BAD_CAFE, 1'b0, RAM_LAT + 1});
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0040;
        n = 0;
        do begin @(negedge clk); n++; end while (!mio_ready && n < 40);
        r = cpu_rdata;
        e = sb_q.pop_front();
        nchecks++; if (n !== e.lat || r !== e.rdata) begin nfail++; $display("FAIL b2b_first: got %0d/%h expected %0d/%h", n, r, e.lat, e.rdata); end
        cpu_addr = 32'h0000_0044;
        @(negedge clk);
        idle_rdy = mio_ready; idle_en = ram_en; idle_addr = ram_addr; idle_st = dut.state_r;
        nchecks++; if (idle_rdy !== 1'b0 || idle_en !== 1'b1 || idle_addr !== 10'h011 || idle_st !== ST_IDLE) begin
            nfail++; $display("FAIL b2b_idle: got rdy=%b en=%b addr=%h st=%0d expected 0/1/011/0", idle_rdy, idle_en, idle_addr, idle_st);
        end
        n = 1;
        do begin @(negedge clk); n++; end while (!mio_ready && n < 40);
        r = cpu_rdata;
        cpu_req = 1'b0;
        e = sb_q.pop_front();
        nchecks++; if (n !== e.lat || r !== e.rdata) begin nfail++; $display("FAIL b2b_second: got gap %0d/%h expected %0d/%h", n, r, e.lat, e.rdata); end
    endtask

    task automatic test_reset_mid_access();
        logic [31:0] rd; logic er; int lat; exp_t e; logic seen; state_e st;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0000_0080; cpu_wdata = 32'hCAFE_F00D;
        @(negedge clk);
        @(negedge clk);
        st = dut.state_r;
        nchecks++; if (st !== ST_RAM_WAIT) begin nfail++; $display("FAIL mid_pre_state: got %0d expected %0d", st, ST_RAM_WAIT); end
        reset = 1'b1; cpu_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        st = dut.state_r;
        nchecks++; if (st !== ST_IDLE) begin nfail++; $display("FAIL mid_state: got %0d expected 0", st); end
        nchecks++; if (gpio_out !== 16'd0 || dut.u_timer.count !== 32'd0 || cpu_rdata !== 32'd0) begin
            nfail++; $display("FAIL mid_regs: got gpio=%h cnt=%h rdata=%h expected 0/0/0", gpio_out, dut.u_timer.count, cpu_rdata);
        end
        seen = mio_ready | ram_we;
        repeat (6) begin @(negedge clk); seen |= mio_ready | ram_we; end
        nchecks++; if (seen !== 1'b0) begin nfail++; $display("FAIL mid_no_ready: got %b expected 0", seen); end
        sb_q.push_back('{32'd7, 1'b0, 1});
        sb_q.push_back('{32'h1234_5678, 1'b0, RAM_LAT});
        cpu_access(1'b0, 32'hF000_0004, 32'h0, rd, er, lat);
        e = sb_q.pop_front();
        nchecks++; if (lat !== e.lat || rd !== e.rdata) begin nfail++; $display("FAIL mid_cnt_rd: got %0d/%h expected %0d/%h", lat, rd, e.lat, e.rdata); end
        cpu_access(1'b0, 32'h0000_0040, 32'h0, rd, er, lat);
        e = sb_q.pop_front();
        nchecks++; if (lat !== e.lat || rd !== e.rdata || er !== e.err) begin nfail++; $display("FAIL mid_ram_rd: got %0d/%h/%b expected %0d/%h/%b", lat, rd, er, e.lat, e.rdata, e.err); end
    endtask

    initial begin
        reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'd0; cpu_wdata = 32'd0; sw_in = 16'd0;
        test_reset();
        test_ram();
        test_gpio();
        test_sw_unmapped();
        test_timer();
        test_back_to_back();
        test_reset_mid_access();
        $display("End of test - %0d assertions evaluated, %0d failures", nchecks, nfail);
        $finish;
    end

endmodule

// File: doc/mio_bus_ctrl.md
Name: mio_bus_ctrl

Overview:
- Memory/IO bus controller directly downstream of the multi-cycle CPU.
- Consumes the CPU's memory request (address, write data, write enable, request strobe) and returns read data plus a ready handshake.
- Decodes each access to one of four targets: on-chip synchronous RAM (with programmable wait states), a GPIO/LED register, a switch input port, or a timer/compare peripheral.
- Gives the CPU a single uniform wait-state handshake regardless of target.

Parameters:
- RAM_AW, 10, RAM word-address width (RAM depth = 2^RAM_AW words).
- RAM_WAIT, 2, extra wait cycles after the RAM read/write cycle; range 0..15.
- UNMAPPED_RD, 32'h0000_0000, data returned on a read of an unmapped address.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  CPU access request (CPU_MIO); held high until mio_ready.
- cpu_we  in  1  1 = write, 0 = read; valid while cpu_req is high.
- cpu_addr  in  32  byte address; bits [1:0] ignored (word access only).
- cpu_wdata  in  32  write data.
- cpu_rdata  out  32  read data; valid in the mio_ready cycle.
- mio_ready  out  1  one-cycle completion pulse.
- bus_err  out  1  one-cycle pulse, coincident with mio_ready, for an unmapped access.
- ram_en  out  1  RAM enable.
- ram_we  out  1  RAM write enable.
- ram_addr  out  RAM_AW  RAM word address, = cpu_addr[RAM_AW+1:2].
- ram_wdata  out  32  RAM write data.
- ram_rdata  in  32  RAM read data; valid the cycle after ram_en.
- sw_in  in  16  switch inputs.
- gpio_out  out  16  LED/GPIO register.
- timer_irq  out  1  sticky compare-match flag.

Behaviour:
- Address map (decode on cpu_addr[31:28], then low bits):
  - 0x0-------: RAM.
  - 0xE0000000: GPIO, R/W, bits [15:0]; upper read bits are 0.
  - 0xF0000000: switches, read-only; a write is ignored but still completes normally.
  - 0xF0000004: timer count, R/W.
  - 0xF0000008: compare, R/W.
  - Anything else is unmapped: write ignored, read returns UNMAPPED_RD, bus_err pulses.
- FSM states: IDLE, RAM_ACC, RAM_WAIT, RESP.
- IDLE:
  - cpu_req=1 and RAM target: assert ram_en (and ram_we = cpu_we) for exactly one cycle, latch address and data, go to RAM_ACC.
  - cpu_req=1 and non-RAM target: perform the register write or read capture this cycle, go to RESP.
- RAM_ACC: capture ram_rdata into the read-data register. Go to RAM_WAIT if RAM_WAIT > 0, else go to RESP.
- RAM_WAIT: 4-bit counter loaded with RAM_WAIT-1 on entry, decrements each cycle; at 0, go to RESP.
- RESP: mio_ready=1 for one cycle (bus_err as applicable), cpu_rdata driven from the capture register, then return to IDLE.
- Latency, with request sampled in cycle t:
  - Peripheral: mio_ready at t+1.
  - RAM: mio_ready at t+2+RAM_WAIT.
- Handshake:
  - The request is accepted only in IDLE.
  - cpu_req still high in the cycle after mio_ready is treated as a new access.
  - Changes to cpu_addr, cpu_we or cpu_wdata after acceptance have no effect (all are latched).
- cpu_rdata holds its last value outside the RESP cycle. After a write access it returns 0.
- Timer:
  - 32-bit count increments every cycle and wraps from 0xFFFFFFFF to 0.
  - A CPU write to the count loads cpu_wdata; the write wins over that cycle's increment.
  - timer_irq is set when count == compare.
  - Any write to compare clears timer_irq; the clear wins over a same-cycle match.
- Reset (synchronous, any state, including mid-RAM-access):
  - FSM returns to IDLE.
  - mio_ready=0, bus_err=0, ram_en=0, ram_we=0.
  - cpu_rdata=0, gpio_out=0, count=0, compare=0xFFFFFFFF, timer_irq=0.
  - No RAM write is issued after reset.

Decomposition:
- Shared package mio_pkg holds:
  - state enum;
  - address-map constants: base addresses and decode masks;
  - target-select enum: RAM, GPIO, SW, TMR_CNT, TMR_CMP, NONE.
- One natural sub-module, mio_timer: count/compare registers and irq logic with a write/read port. The FSM and decode stay in the top.

Test Plan:
- RAM write then read, RAM_WAIT=2: write 0x12345678 to 0x00000040, then read it back. Required:
  - ram_addr=0x010, ram_we pulsed exactly one cycle;
  - each mio_ready arrives 4 cycles after the request;
  - read returns 0x12345678.
- GPIO: write 0xFFFFA5A5 to 0xE0000000. Required: gpio_out=0xA5A5 the cycle after acceptance, mio_ready at t+1. Reading it back returns 0x0000A5A5.
- Switches and unmapped: with sw_in=0x00F0, a read of 0xF0000000 returns 0x000000F0. A read of 0x70000000 returns UNMAPPED_RD with bus_err and mio_ready high in the same cycle.
- Timer:
  - write compare=20, then count=10;
  - timer_irq rises when count reaches 20 and stays high;
  - a write of compare=100 clears it in the cycle it is accepted, even if count==compare that cycle.
- Back-to-back: cpu_req held high across two RAM reads. Required: two distinct mio_ready pulses with exactly one IDLE cycle between the accesses.
- Reset mid-access: assert reset in RAM_WAIT of a write. Required: next cycle FSM=IDLE, mio_ready never pulses, gpio_out=0, count=0; a subsequent read completes normally.
